// File: rtl/subband_scale.sv
// Subband output scaler: per-lane gain from lane/column parity, round-half-away,
// saturate, and count clipped samples per frame. Fixed 3-stage back-pressurable pipe.
module subband_scale #(
  parameter int Lanes    = 2,
  parameter int InWidth  = 16,
  parameter int InPoint  = 10,
  parameter int OutWidth = 16,
  parameter int OutPoint = 10,
  parameter int KWidth   = 25,
  parameter int KPoint   = 20,
  parameter int CntWidth = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [4*KWidth-1:0]          cfg_k_i,
  output logic                         s_ready_o,
  input  logic                         s_valid_i,
  input  logic                         s_sof_i,
  input  logic                         s_eol_i,
  input  logic [Lanes*InWidth-1:0]     s_data_i,
  input  logic                         m_ready_i,
  output logic                         m_valid_o,
  output logic                         m_sof_o,
  output logic                         m_eol_o,
  output logic [Lanes*OutWidth-1:0]    m_data_o,
  output logic [CntWidth-1:0]          sat_cnt_o
);

  localparam int PW = InWidth + KWidth;
  localparam int SH = InPoint + KPoint - OutPoint;
  localparam int CW = $clog2(Lanes + 1);

  localparam logic [PW:0]        ONE     = {{PW{1'b0}}, 1'b1};
  localparam logic signed [PW:0] RND_POS = $signed(ONE << (SH - 1));
  localparam logic signed [PW:0] RND_NEG = RND_POS - $signed(ONE);
  localparam logic signed [PW:0] OUT_MAX = $signed(ONE << (OutWidth - 1)) - $signed(ONE);
  localparam logic signed [PW:0] OUT_MIN = -$signed(ONE << (OutWidth - 1));

  // Gain slot {lane odd, column odd}: 0=LL, 1=HL, 2=LH, 3=HH.
  function automatic logic [1:0] band_idx(input int lane, input logic par);
    return {lane[0], par};
  endfunction

  // Returns {saturated, value}.
  function automatic logic [OutWidth:0] round_sat(input logic signed [PW-1:0] prod);
    logic signed [PW:0] acc;
    logic [OutWidth:0]  res;
    acc = $signed({prod[PW-1], prod}) + (prod[PW-1] ? RND_NEG : RND_POS);
    acc = acc >>> SH;
    if (acc > OUT_MAX) begin
      res = {1'b1, OUT_MAX[OutWidth-1:0]};
    end else if (acc < OUT_MIN) begin
      res = {1'b1, OUT_MIN[OutWidth-1:0]};
    end else begin
      res = {1'b0, acc[OutWidth-1:0]};
    end
    return res;
  endfunction

  logic                       en, accept, par_use;
  logic                       par_q, par_d;
  logic signed [KWidth-1:0]   kact_q [4];
  logic                       v1_q, sof1_q, eol1_q;
  logic signed [InWidth-1:0]  d1_q [Lanes];
  logic signed [KWidth-1:0]   k1_q [Lanes];
  logic signed [KWidth-1:0]   k1_d [Lanes];
  logic                       v2_q, sof2_q, eol2_q;
  logic signed [PW-1:0]       p2_q [Lanes];
  logic [OutWidth:0]          rs [Lanes];
  logic                       m_valid_q, m_sof_q, m_eol_q;
  logic [Lanes*OutWidth-1:0]  m_data_q, m_data_d;
  logic [CntWidth-1:0]        sat_cnt_q, sat_cnt_d;
  logic [CntWidth:0]          sat_sum;
  logic [CW-1:0]              nsat;

  // Handshake, column parity and per-lane gain selection for the incoming beat.
  always_comb begin
    en      = m_ready_i | ~m_valid_q;
    accept  = s_valid_i & en;
    par_use = s_sof_i ? 1'b0 : par_q;
    if (accept) begin
      par_d = s_eol_i ? 1'b0 : ~par_use;
    end else begin
      par_d = par_q;
    end
    // A sof beat already uses the gains it is loading.
    for (int l = 0; l < Lanes; l++) begin
      if (s_sof_i) begin
        k1_d[l] = cfg_k_i[int'(band_idx(l, par_use))*KWidth +: KWidth];
      end else begin
        k1_d[l] = kact_q[band_idx(l, par_use)];
      end
    end
  end

  // Stage 1: gain latch, parity and input register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      par_q  <= 1'b0;
      v1_q   <= 1'b0;
      sof1_q <= 1'b0;
      eol1_q <= 1'b0;
      for (int k = 0; k < 4; k++) kact_q[k] <= '0;
      for (int l = 0; l < Lanes; l++) begin
        d1_q[l] <= '0;
        k1_q[l] <= '0;
      end
    end else begin
      par_q <= par_d;
      if (accept && s_sof_i) begin
        for (int k = 0; k < 4; k++) kact_q[k] <= cfg_k_i[k*KWidth +: KWidth];
      end
      if (en) begin
        v1_q   <= s_valid_i;
        sof1_q <= s_sof_i;
        eol1_q <= s_eol_i;
        for (int l = 0; l < Lanes; l++) begin
          d1_q[l] <= s_data_i[l*InWidth +: InWidth];
          k1_q[l] <= k1_d[l];
        end
      end
    end
  end

  // Stage 2: full-width signed multiply.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v2_q   <= 1'b0;
      sof2_q <= 1'b0;
      eol2_q <= 1'b0;
      for (int l = 0; l < Lanes; l++) p2_q[l] <= '0;
    end else if (en) begin
      v2_q   <= v1_q;
      sof2_q <= sof1_q;
      eol2_q <= eol1_q;
      for (int l = 0; l < Lanes; l++) p2_q[l] <= PW'(d1_q[l]) * PW'(k1_q[l]);
    end
  end

  // Round, saturate and count clipped lanes for the beat leaving stage 2.
  always_comb begin
    nsat = '0;
    for (int l = 0; l < Lanes; l++) begin
      rs[l] = round_sat(p2_q[l]);
      m_data_d[l*OutWidth +: OutWidth] = rs[l][OutWidth-1:0];
      nsat = nsat + CW'(rs[l][OutWidth]);
    end
    sat_sum = {1'b0, sat_cnt_q} + (CntWidth+1)'(nsat);
    if (sof2_q) begin
      sat_cnt_d = CntWidth'(nsat);
    end else if (sat_sum[CntWidth]) begin
      sat_cnt_d = '1;
    end else begin
      sat_cnt_d = sat_sum[CntWidth-1:0];
    end
  end

  // Stage 3: output register and saturation counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_valid_q <= 1'b0;
      m_sof_q   <= 1'b0;
      m_eol_q   <= 1'b0;
      m_data_q  <= '0;
      sat_cnt_q <= '0;
    end else if (en) begin
      m_valid_q <= v2_q;
      if (v2_q) begin
        m_sof_q   <= sof2_q;
        m_eol_q   <= eol2_q;
        m_data_q  <= m_data_d;
        sat_cnt_q <= sat_cnt_d;
      end
    end
  end

  assign s_ready_o = en;
  assign m_valid_o = m_valid_q;
  assign m_sof_o   = m_sof_q;
  assign m_eol_o   = m_eol_q;
  assign m_data_o  = m_data_q;
  assign sat_cnt_o = sat_cnt_q;

endmodule

// File: tb/tb_subband_scale.sv
// Table-driven bench for subband_scale with an output scoreboard queue.
module tb_subband_scale;

  localparam int KW = 25;
  localparam logic [KW-1:0] G1   = 25'h100000;
  localparam logic [KW-1:0] G05  = 25'h080000;
  localparam logic [KW-1:0] G2   = 25'h200000;
  localparam logic [KW-1:0] G025 = 25'h040000;

  typedef struct {
    logic          sof;
    logic          eol;
    logic [4*KW-1:0] cfg;
    logic [31:0]   din;
    logic [31:0]   dout;
    logic [15:0]   sat;
  } vec_t;

  typedef struct {
    logic        sof;
    logic        eol;
    logic [31:0] data;
    logic [15:0] sat;
  } exp_t;

  logic            clk;
  logic            rst_ni;
  logic [4*KW-1:0] cfg_k_i;
  logic            s_ready_o, s_valid_i, s_sof_i, s_eol_i;
  logic [31:0]     s_data_i;
  logic            m_ready_i, m_valid_o, m_sof_o, m_eol_o;
  logic [31:0]     m_data_o;
  logic [15:0]     sat_cnt_o;

  subband_scale dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .cfg_k_i   (cfg_k_i),
    .s_ready_o (s_ready_o),
    .s_valid_i (s_valid_i),
    .s_sof_i   (s_sof_i),
    .s_eol_i   (s_eol_i),
    .s_data_i  (s_data_i),
    .m_ready_i (m_ready_i),
    .m_valid_o (m_valid_o),
    .m_sof_o   (m_sof_o),
    .m_eol_o   (m_eol_o),
    .m_data_o  (m_data_o),
    .sat_cnt_o (sat_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     checks_total;
  int     checks_passed;
  exp_t   sbq[$];
  vec_t   vecs[12];
  logic   bp_mode;
  logic   rdy_cmd;
  logic [3:0] bp_pat;

  function automatic logic [4*KW-1:0] mk_cfg(input logic [KW-1:0] ll, input logic [KW-1:0] hl,
                                             input logic [KW-1:0] lh, input logic [KW-1:0] hh);
    return {hh, lh, hl, ll};
  endfunction

  task automatic chk(input logic ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks_total++;
    if (ok) checks_passed++;
    else $display("FAIL %s: actual %0h required %0h", name, act, req);
  endtask

  // Drive one beat starting at a negedge; push expectation when accepted.
  task automatic send(input vec_t v);
    logic acc;
    int   n;
    exp_t e;
    s_valid_i = 1'b1;
    s_sof_i   = v.sof;
    s_eol_i   = v.eol;
    cfg_k_i   = v.cfg;
    s_data_i  = v.din;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 200) begin
      #4;
      acc = s_ready_o;
      if (acc) begin
        e = '{sof: v.sof, eol: v.eol, data: v.dout, sat: v.sat};
        sbq.push_back(e);
      end
      @(negedge clk);
      n++;
    end
    if (!acc) chk(1'b0, "accept_timeout", 64'(n), 64'd0);
    s_valid_i = 1'b0;
    s_sof_i   = 1'b0;
    s_eol_i   = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(sbq.size() == 0, "drain", 64'(sbq.size()), 64'd0);
  endtask

  // Downstream ready: fixed 1,0,0,1 pattern in backpressure mode.
  initial begin
    int bp_idx;
    bp_idx = 0;
    forever begin
      @(negedge clk);
      if (bp_mode) begin
        m_ready_i = bp_pat[bp_idx];
        bp_idx = (bp_idx + 1) % 4;
      end else begin
        m_ready_i = rdy_cmd;
      end
    end
  end

  // Output monitor: scoreboard compare, stall stability and ready checks.
  initial begin
    logic        stalled;
    logic [31:0] held_data;
    logic        held_sof, held_eol;
    exp_t        e;
    stalled = 1'b0;
    held_data = '0;
    held_sof = 1'b0;
    held_eol = 1'b0;
    forever begin
      @(negedge clk);
      #4;
      if (!rst_ni) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          chk(m_valid_o === 1'b1, "hold_valid", 64'(m_valid_o), 64'd1);
          chk(m_data_o === held_data && m_sof_o === held_sof && m_eol_o === held_eol,
              "hold_data", 64'(m_data_o), 64'(held_data));
        end
        if (m_valid_o && !m_ready_i) begin
          chk(s_ready_o === 1'b0, "s_ready_stall", 64'(s_ready_o), 64'd0);
          stalled = 1'b1;
          held_data = m_data_o;
          held_sof = m_sof_o;
          held_eol = m_eol_o;
        end else begin
          stalled = 1'b0;
        end
        if (m_valid_o && m_ready_i) begin
          if (sbq.size() == 0) begin
            chk(1'b0, "unexpected_beat", 64'(m_data_o), 64'd0);
          end else begin
            e = sbq.pop_front();
            chk(m_data_o === e.data, "data", 64'(m_data_o), 64'(e.data));
            chk(m_sof_o === e.sof, "sof", 64'(m_sof_o), 64'(e.sof));
            chk(m_eol_o === e.eol, "eol", 64'(m_eol_o), 64'(e.eol));
            chk(sat_cnt_o === e.sat, "sat_cnt", 64'(sat_cnt_o), 64'(e.sat));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    bp_pat    = 4'b1001;
    bp_mode   = 1'b0;
    rdy_cmd   = 1'b1;
    m_ready_i = 1'b1;
    rst_ni    = 1'b0;
    s_valid_i = 1'b0;
    s_sof_i   = 1'b0;
    s_eol_i   = 1'b0;
    s_data_i  = '0;
    cfg_k_i   = '0;
    checks_total  = 0;
    checks_passed = 0;

    vecs[0]  = '{1'b1, 1'b1, mk_cfg(G1, G1, G1, G1),         {16'hFC00, 16'h0400}, {16'hFC00, 16'h0400}, 16'd0};
    vecs[1]  = '{1'b1, 1'b0, mk_cfg(G1, G05, G2, G025),      {16'h0100, 16'h0400}, {16'h0200, 16'h0400}, 16'd0};
    vecs[2]  = '{1'b0, 1'b1, mk_cfg(25'h1, 25'h1, 25'h1, 25'h1), {16'h0100, 16'h0400}, {16'h0040, 16'h0200}, 16'd0};
    vecs[3]  = '{1'b0, 1'b0, mk_cfg(25'h1, 25'h1, 25'h1, 25'h1), {16'h0100, 16'h0400}, {16'h0200, 16'h0400}, 16'd0};
    vecs[4]  = '{1'b0, 1'b1, mk_cfg(25'h1, 25'h1, 25'h1, 25'h1), {16'h0100, 16'h0400}, {16'h0040, 16'h0200}, 16'd0};
    vecs[5]  = '{1'b1, 1'b0, mk_cfg(G05, G05, G05, G05),     {16'hFFFF, 16'h0001}, {16'hFFFF, 16'h0001}, 16'd0};
    vecs[6]  = '{1'b0, 1'b1, mk_cfg(G05, G05, G05, G05),     {16'hFFFD, 16'h0003}, {16'hFFFE, 16'h0002}, 16'd0};
    vecs[7]  = '{1'b1, 1'b1, mk_cfg(G2, G2, G2, G2),         {16'h8000, 16'h7FFF}, {16'h8000, 16'h7FFF}, 16'd2};
    vecs[8]  = '{1'b0, 1'b1, mk_cfg(G1, G1, G1, G1),         {16'h8000, 16'h7FFF}, {16'h8000, 16'h7FFF}, 16'd4};
    vecs[9]  = '{1'b1, 1'b1, mk_cfg(G2, G1, G1, G05),        {16'h0100, 16'h0400}, {16'h0100, 16'h0800}, 16'd0};
    vecs[10] = '{1'b0, 1'b0, '0,                             {16'h0100, 16'h0400}, {16'h0100, 16'h0800}, 16'd0};
    vecs[11] = '{1'b0, 1'b1, '0,                             {16'h0100, 16'h0400}, {16'h0080, 16'h0400}, 16'd0};

    repeat (3) @(negedge clk);
    chk(m_valid_o === 1'b0, "reset_valid", 64'(m_valid_o), 64'd0);
    chk(m_data_o === 32'd0, "reset_data", 64'(m_data_o), 64'd0);
    chk(sat_cnt_o === 16'd0, "reset_sat", 64'(sat_cnt_o), 64'd0);
    rst_ni = 1'b1;
    #1;
    chk(s_ready_o === 1'b1, "reset_ready", 64'(s_ready_o), 64'd1);
    @(negedge clk);

    send(vecs[0]);
    chk(m_valid_o === 1'b0, "latency_c1", 64'(m_valid_o), 64'd0);
    @(negedge clk);
    chk(m_valid_o === 1'b0, "latency_c2", 64'(m_valid_o), 64'd0);
    @(negedge clk);
    chk(m_valid_o === 1'b1, "latency_c3", 64'(m_valid_o), 64'd1);

    for (int i = 1; i < 12; i++) send(vecs[i]);
    drain();

    bp_mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      v.sof  = (i == 0);
      v.eol  = (i == 7);
      v.cfg  = mk_cfg(G1, G1, G1, G1);
      v.din  = $urandom();
      v.dout = v.din;
      v.sat  = 16'd0;
      send(v);
    end
    drain();
    bp_mode = 1'b0;

    // Reset with three beats in flight while the output is stalled.
    rdy_cmd = 1'b0;
    @(negedge clk);
    send('{1'b1, 1'b0, mk_cfg(G2, G2, G2, G2), {16'h8000, 16'h7FFF}, {16'h8000, 16'h7FFF}, 16'd2});
    send('{1'b0, 1'b0, '0, {16'h0001, 16'h0002}, {16'h0002, 16'h0004}, 16'd2});
    send('{1'b0, 1'b1, '0, {16'h0003, 16'h0004}, {16'h0006, 16'h0008}, 16'd2});
    chk(m_valid_o === 1'b1, "stall_valid", 64'(m_valid_o), 64'd1);
    chk(sat_cnt_o === 16'd2, "stall_sat", 64'(sat_cnt_o), 64'd2);
    #2;
    rst_ni = 1'b0;
    #1;
    chk(m_valid_o === 1'b0, "async_reset_valid", 64'(m_valid_o), 64'd0);
    chk(sat_cnt_o === 16'd0, "async_reset_sat", 64'(sat_cnt_o), 64'd0);
    sbq.delete();
    @(negedge clk);
    rst_ni  = 1'b1;
    rdy_cmd = 1'b1;
    #1;
    chk(s_ready_o === 1'b1, "release_ready", 64'(s_ready_o), 64'd1);
    @(negedge clk);
    send('{1'b0, 1'b1, mk_cfg(G1, G1, G1, G1), {16'h0400, 16'h0400}, 32'd0, 16'd0});
    send('{1'b1, 1'b1, mk_cfg(G1, G05, G2, G025), {16'h0100, 16'h0400}, {16'h0200, 16'h0400}, 16'd0});
    send('{1'b0, 1'b1, '0, {16'h0100, 16'h0400}, {16'h0200, 16'h0400}, 16'd0});
    drain();
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
